// File: rtl/vga_pkg.sv
// Shared tile-screen geometry, ASCII control codes and text writer state type.
package vga_pkg;

  localparam int H_TILES        = 160;
  localparam int V_TILES        = 64;
  localparam int ADDR_COL_WIDTH = 8;
  localparam int ADDR_ROW_WIDTH = 6;
  localparam int DATA_WIDTH     = 7;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_HT    = 8'h09;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLR_LINE   = 2'd1,
    ST_CLR_SCREEN = 2'd2
  } tw_state_e;

  // The screen never scrolls: the row index wraps to the top instead.
  function automatic logic [ADDR_ROW_WIDTH-1:0] next_row(input logic [ADDR_ROW_WIDTH-1:0] row);
    logic [ADDR_ROW_WIDTH-1:0] nxt;
    if (row == ADDR_ROW_WIDTH'(V_TILES - 1)) begin
      nxt = {ADDR_ROW_WIDTH{1'b0}};
    end else begin
      nxt = row + ADDR_ROW_WIDTH'(1);
    end
    return nxt;
  endfunction

  // One extra bit so a tab stop past the last column is still representable.
  function automatic logic [ADDR_COL_WIDTH:0] next_tab_stop(input logic [ADDR_COL_WIDTH-1:0] col);
    logic [ADDR_COL_WIDTH:0] stop;
    stop = {1'b0, col} | (ADDR_COL_WIDTH + 1)'(7);
    return stop + (ADDR_COL_WIDTH + 1)'(1);
  endfunction

endpackage

// File: rtl/text_writer_if.sv
// Byte-stream handshake plus tile-buffer write port of the text writer.
interface text_writer_if;
  import vga_pkg::*;

  logic [7:0]                char_i;
  logic                      valid_i;
  logic                      ready_o;
  logic                      wr_en_o;
  logic [ADDR_COL_WIDTH-1:0] col_w_o;
  logic [ADDR_ROW_WIDTH-1:0] row_w_o;
  logic [DATA_WIDTH-1:0]     din_o;

  modport master (
    output char_i,
    output valid_i,
    input  ready_o,
    input  wr_en_o,
    input  col_w_o,
    input  row_w_o,
    input  din_o
  );

  modport slave (
    input  char_i,
    input  valid_i,
    output ready_o,
    output wr_en_o,
    output col_w_o,
    output row_w_o,
    output din_o
  );

endinterface

// File: rtl/tile_sweep.sv
// Row/column sweep counter: walks one tile row or the whole grid, one cell per cycle,
// and flags the final cell with a single-cycle done pulse.
module tile_sweep
  import vga_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  input  logic                      full_i,
  input  logic [ADDR_ROW_WIDTH-1:0] row_i,
  output logic [ADDR_COL_WIDTH-1:0] col_o,
  output logic [ADDR_ROW_WIDTH-1:0] row_o,
  output logic                      done_o
);

  localparam logic [ADDR_COL_WIDTH-1:0] COL_LAST = ADDR_COL_WIDTH'(H_TILES - 1);
  localparam logic [ADDR_ROW_WIDTH-1:0] ROW_LAST = ADDR_ROW_WIDTH'(V_TILES - 1);

  logic                      active_r;
  logic                      full_r;
  logic [ADDR_COL_WIDTH-1:0] col_r;
  logic [ADDR_ROW_WIDTH-1:0] row_r;
  logic                      row_end_s;
  logic                      done_s;

  assign row_end_s = (col_r == COL_LAST);
  assign done_s    = active_r && row_end_s && (!full_r || (row_r == ROW_LAST));

  // Sweep position; a start always restarts from column 0 of the chosen row.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      active_r <= 1'b0;
      full_r   <= 1'b0;
      col_r    <= {ADDR_COL_WIDTH{1'b0}};
      row_r    <= {ADDR_ROW_WIDTH{1'b0}};
    end else if (start_i) begin
      active_r <= 1'b1;
      full_r   <= full_i;
      col_r    <= {ADDR_COL_WIDTH{1'b0}};
      row_r    <= full_i ? {ADDR_ROW_WIDTH{1'b0}} : row_i;
    end else if (done_s) begin
      active_r <= 1'b0;
      col_r    <= {ADDR_COL_WIDTH{1'b0}};
    end else if (active_r) begin
      if (row_end_s) begin
        col_r <= {ADDR_COL_WIDTH{1'b0}};
        row_r <= row_r + ADDR_ROW_WIDTH'(1);
      end else begin
        col_r <= col_r + ADDR_COL_WIDTH'(1);
      end
    end
  end

  assign col_o  = col_r;
  assign row_o  = row_r;
  assign done_o = done_s;

endmodule

// File: rtl/text_writer.sv
// Character-stream front end for the tile screen buffer: cursor handling, control codes
// and row/screen clears. Define TEXT_WRITER_TAB_EN to enable horizontal tab (0x09).
module text_writer
  import vga_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rstn_i,
  text_writer_if.slave              bus,
  output logic [ADDR_COL_WIDTH-1:0] cursor_col_o,
  output logic [ADDR_ROW_WIDTH-1:0] cursor_row_o,
  output logic                      busy_o
);

  localparam logic [ADDR_COL_WIDTH-1:0] COL_LAST = ADDR_COL_WIDTH'(H_TILES - 1);

  tw_state_e                 state_r, state_n_s;
  logic [ADDR_COL_WIDTH-1:0] cursor_col_r, cursor_col_n_s;
  logic [ADDR_ROW_WIDTH-1:0] cursor_row_r, cursor_row_n_s;
  logic                      wr_en_r, wr_en_n_s;
  logic [ADDR_COL_WIDTH-1:0] col_w_r, col_w_n_s;
  logic [ADDR_ROW_WIDTH-1:0] row_w_r, row_w_n_s;
  logic [DATA_WIDTH-1:0]     din_r, din_n_s;
  logic                      sweep_start_s;
  logic                      sweep_full_s;
  logic [ADDR_COL_WIDTH-1:0] sweep_col_s;
  logic [ADDR_ROW_WIDTH-1:0] sweep_row_s;
  logic                      sweep_done_s;
  logic                      accept_s;
  logic                      printable_s;

  assign accept_s    = bus.valid_i && (state_r == ST_IDLE);
  assign printable_s = (bus.char_i >= ASCII_SPACE) && (bus.char_i <= ASCII_TILDE);

`ifdef TEXT_WRITER_TAB_EN
  localparam logic [ADDR_COL_WIDTH:0] TAB_LIMIT = (ADDR_COL_WIDTH + 1)'(H_TILES);
  logic [ADDR_COL_WIDTH:0] tab_stop_s;
  assign tab_stop_s = next_tab_stop(cursor_col_r);
`endif

  // The sweep row follows the freshly advanced cursor row, so it starts with the accept.
  tile_sweep u_sweep (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .start_i (sweep_start_s),
    .full_i  (sweep_full_s),
    .row_i   (cursor_row_n_s),
    .col_o   (sweep_col_s),
    .row_o   (sweep_row_s),
    .done_o  (sweep_done_s)
  );

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_n_s      = state_r;
    cursor_col_n_s = cursor_col_r;
    cursor_row_n_s = cursor_row_r;
    wr_en_n_s      = 1'b0;
    col_w_n_s      = col_w_r;
    row_w_n_s      = row_w_r;
    din_n_s        = din_r;
    sweep_start_s  = 1'b0;
    sweep_full_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && printable_s) begin
          wr_en_n_s = 1'b1;
          col_w_n_s = cursor_col_r;
          row_w_n_s = cursor_row_r;
          din_n_s   = bus.char_i[DATA_WIDTH-1:0];
          if (cursor_col_r != COL_LAST) begin
            cursor_col_n_s = cursor_col_r + ADDR_COL_WIDTH'(1);
          end else begin
            cursor_col_n_s = {ADDR_COL_WIDTH{1'b0}};
            cursor_row_n_s = next_row(cursor_row_r);
            state_n_s      = ST_CLR_LINE;
            sweep_start_s  = 1'b1;
          end
        end else if (accept_s) begin
          case (bus.char_i)
            ASCII_LF: begin
              cursor_col_n_s = {ADDR_COL_WIDTH{1'b0}};
              cursor_row_n_s = next_row(cursor_row_r);
              state_n_s      = ST_CLR_LINE;
              sweep_start_s  = 1'b1;
            end
            ASCII_CR: begin
              cursor_col_n_s = {ADDR_COL_WIDTH{1'b0}};
            end
            ASCII_BS: begin
              // Backspace stops at column 0; it never climbs to the previous row.
              if (cursor_col_r != {ADDR_COL_WIDTH{1'b0}}) begin
                cursor_col_n_s = cursor_col_r - ADDR_COL_WIDTH'(1);
                wr_en_n_s      = 1'b1;
                col_w_n_s      = cursor_col_r - ADDR_COL_WIDTH'(1);
                row_w_n_s      = cursor_row_r;
                din_n_s        = {DATA_WIDTH{1'b0}};
              end else begin
                cursor_col_n_s = cursor_col_r;
              end
            end
            ASCII_FF: begin
              cursor_col_n_s = {ADDR_COL_WIDTH{1'b0}};
              cursor_row_n_s = {ADDR_ROW_WIDTH{1'b0}};
              state_n_s      = ST_CLR_SCREEN;
              sweep_start_s  = 1'b1;
              sweep_full_s   = 1'b1;
            end
`ifdef TEXT_WRITER_TAB_EN
            ASCII_HT: begin
              if (tab_stop_s >= TAB_LIMIT) begin
                cursor_col_n_s = {ADDR_COL_WIDTH{1'b0}};
                cursor_row_n_s = next_row(cursor_row_r);
                state_n_s      = ST_CLR_LINE;
                sweep_start_s  = 1'b1;
              end else begin
                cursor_col_n_s = tab_stop_s[ADDR_COL_WIDTH-1:0];
              end
            end
`endif
            default: begin
              state_n_s = ST_IDLE;
            end
          endcase
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_CLR_LINE, ST_CLR_SCREEN: begin
        wr_en_n_s = 1'b1;
        col_w_n_s = sweep_col_s;
        row_w_n_s = sweep_row_s;
        din_n_s   = {DATA_WIDTH{1'b0}};
        if (sweep_done_s) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = state_r;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State, cursor and registered write port.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r      <= ST_IDLE;
      cursor_col_r <= {ADDR_COL_WIDTH{1'b0}};
      cursor_row_r <= {ADDR_ROW_WIDTH{1'b0}};
      wr_en_r      <= 1'b0;
      col_w_r      <= {ADDR_COL_WIDTH{1'b0}};
      row_w_r      <= {ADDR_ROW_WIDTH{1'b0}};
      din_r        <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r      <= state_n_s;
      cursor_col_r <= cursor_col_n_s;
      cursor_row_r <= cursor_row_n_s;
      wr_en_r      <= wr_en_n_s;
      col_w_r      <= col_w_n_s;
      row_w_r      <= row_w_n_s;
      din_r        <= din_n_s;
    end
  end

  assign bus.ready_o   = (state_r == ST_IDLE);
  assign bus.wr_en_o   = wr_en_r;
  assign bus.col_w_o   = col_w_r;
  assign bus.row_w_o   = row_w_r;
  assign bus.din_o     = din_r;
  assign cursor_col_o  = cursor_col_r;
  assign cursor_row_o  = cursor_row_r;
  assign busy_o        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_text_writer.sv
// Self-checking bench for text_writer: directed scenarios plus randomized bytes checked
// against a cursor/write-list model of the screen rules.
`timescale 1ns/1ps
module tb_text_writer;
  import vga_pkg::*;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic [ADDR_COL_WIDTH-1:0] cursor_col;
  logic [ADDR_ROW_WIDTH-1:0] cursor_row;
  logic                      busy;

  text_writer_if tw_if ();

  text_writer dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .bus          (tw_if),
    .cursor_col_o (cursor_col),
    .cursor_row_o (cursor_row),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          m_col    = 0;
  int          m_row    = 0;
  bit          mon_en   = 1'b0;
  logic [20:0] exp_q[$];
  logic [20:0] act_q[$];

  // Write monitor: {col, row, data} of every presented buffer write.
  always @(negedge clk) begin
    if (mon_en && rstn === 1'b1 && tw_if.wr_en_o === 1'b1)
      act_q.push_back({tw_if.col_w_o, tw_if.row_w_o, tw_if.din_o});
  end

  function automatic void push_wr(int c, int r, int d);
    logic [7:0] cc = 8'(c);
    logic [5:0] rr = 6'(r);
    logic [6:0] dd = 7'(d);
    exp_q.push_back({cc, rr, dd});
  endfunction

  function automatic void model_newline();
    m_col = 0;
    m_row = (m_row + 1) % 64;
    for (int c = 0; c < 160; c++) push_wr(c, m_row, 0);
  endfunction

  function automatic void model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(m_col, m_row, int'(b) % 128);
      if (m_col + 1 < 160) m_col++;
      else model_newline();
    end else if (b == 8'h0A) model_newline();
    else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h08) begin
      if (m_col > 0) begin m_col--; push_wr(m_col, m_row, 0); end
    end else if (b == 8'h0C) begin
      m_col = 0; m_row = 0;
      for (int r = 0; r < 64; r++) for (int c = 0; c < 160; c++) push_wr(c, r, 0);
    end
`ifdef TEXT_WRITER_TAB_EN
    else if (b == 8'h09) begin
      if ((m_col / 8 + 1) * 8 >= 160) model_newline();
      else m_col = (m_col / 8 + 1) * 8;
    end
`endif
  endfunction

  // Index of the first differing write, or -1 when both lists are identical.
  function automatic int stream_diff();
    int n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (act_q[i] !== exp_q[i]) return i;
    if (act_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    tw_if.char_i  = b;
    tw_if.valid_i = 1'b1;
    while (tw_if.ready_o !== 1'b1 && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20000) begin
      checks++; failures++;
      $display("FAIL send_timeout: ready_o=%b required 1", tw_if.ready_o);
    end
    @(negedge clk);
    tw_if.valid_i = 1'b0;
    model_apply(b);
  endtask

  task automatic settle();
    int waited = 0;
    @(negedge clk);
    while ((tw_if.ready_o !== 1'b1 || tw_if.wr_en_o !== 1'b0) && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20000) begin
      checks++; failures++;
      $display("FAIL settle_timeout: ready_o=%b wr_en_o=%b required 1/0", tw_if.ready_o, tw_if.wr_en_o);
    end
  endtask

  task automatic test_reset();
    tw_if.valid_i = 1'b0;
    tw_if.char_i  = 8'h00;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tw_if.wr_en_o, tw_if.col_w_o, tw_if.row_w_o, tw_if.din_o, cursor_col, cursor_row, busy} !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs: wr_en=%b col_w=%0d row_w=%0d din=%h cur=(%0d,%0d) busy=%b required all 0",
               tw_if.wr_en_o, tw_if.col_w_o, tw_if.row_w_o, tw_if.din_o, cursor_col, cursor_row, busy);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (tw_if.ready_o !== 1'b1 || busy !== 1'b0 || tw_if.wr_en_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b busy=%b wr_en=%b required 1/0/0", tw_if.ready_o, busy, tw_if.wr_en_o);
    end
    m_col = 0; m_row = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_single_char();
    tw_if.char_i  = 8'h41;
    tw_if.valid_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tw_if.wr_en_o !== 1'b1 || tw_if.col_w_o !== 8'd0 || tw_if.row_w_o !== 6'd0 || tw_if.din_o !== 7'h41) begin
      failures++;
      $display("FAIL char_write: wr_en=%b col=%0d row=%0d din=%h required 1/0/0/41",
               tw_if.wr_en_o, tw_if.col_w_o, tw_if.row_w_o, tw_if.din_o);
    end
    checks++;
    if (cursor_col !== 8'd1 || cursor_row !== 6'd0 || tw_if.ready_o !== 1'b1) begin
      failures++;
      $display("FAIL char_cursor: cur=(%0d,%0d) ready=%b required (1,0) 1", cursor_col, cursor_row, tw_if.ready_o);
    end
    tw_if.valid_i = 1'b0;
    model_apply(8'h41);
    @(posedge clk); #1;
    checks++;
    if (tw_if.wr_en_o !== 1'b0) begin
      failures++;
      $display("FAIL char_one_cycle: wr_en=%b required 0", tw_if.wr_en_o);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int busy_n = 0;
    int waited = 0;
    int d;
    send_byte(8'h0D);
    for (int i = 0; i < 160; i++) send_byte(8'h78);
    checks++;
    if (cursor_col !== 8'd0 || cursor_row !== 6'd1 || busy !== 1'b1 || tw_if.ready_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_enter: cur=(%0d,%0d) busy=%b ready=%b required (0,1) 1 0",
               cursor_col, cursor_row, busy, tw_if.ready_o);
    end
    tw_if.char_i  = 8'h79;
    tw_if.valid_i = 1'b1;
    while (tw_if.ready_o !== 1'b1 && waited < 1000) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      waited++;
    end
    checks++;
    if (busy_n !== 160) begin
      failures++;
      $display("FAIL wrap_busy_len: busy cycles=%0d required 160", busy_n);
    end
    @(posedge clk); #1;
    checks++;
    if (tw_if.wr_en_o !== 1'b1 || tw_if.col_w_o !== 8'd0 || tw_if.row_w_o !== 6'd1 || tw_if.din_o !== 7'h79) begin
      failures++;
      $display("FAIL held_byte: wr_en=%b col=%0d row=%0d din=%h required 1/0/1/79",
               tw_if.wr_en_o, tw_if.col_w_o, tw_if.row_w_o, tw_if.din_o);
    end
    tw_if.valid_i = 1'b0;
    model_apply(8'h79);
    settle();
    d = stream_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL wrap_stream: first diff at %0d, writes=%0d required %0d", d, act_q.size(), exp_q.size());
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_lf();
    int d;
    int hit = 0;
    send_byte(8'h0D);
    for (int i = 0; i < 62; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h62);
    checks++;
    if (cursor_col !== 8'd5 || cursor_row !== 6'd63) begin
      failures++;
      $display("FAIL lf_setup: cur=(%0d,%0d) required (5,63)", cursor_col, cursor_row);
    end
    settle();
    act_q.delete(); exp_q.delete();
    send_byte(8'h0A);
    checks++;
    if (cursor_col !== 8'd0 || cursor_row !== 6'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL lf_cursor: cur=(%0d,%0d) busy=%b required (0,0) 1", cursor_col, cursor_row, busy);
    end
    settle();
    foreach (act_q[i]) if (act_q[i][20:13] == 8'd5 && act_q[i][12:7] == 6'd63) hit++;
    checks++;
    if (act_q.size() != 160 || hit != 0) begin
      failures++;
      $display("FAIL lf_writes: writes=%0d at(5,63)=%0d required 160 and 0", act_q.size(), hit);
    end
    d = stream_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL lf_stream: first diff at %0d", d);
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_bs_cr();
    logic [20:0] w0 = {8'd2, 6'd2, 7'd0};
    logic [20:0] w1 = {8'd1, 6'd2, 7'd0};
    send_byte(8'h0A);
    send_byte(8'h0A);
    for (int i = 0; i < 3; i++) send_byte(8'h63);
    settle();
    act_q.delete(); exp_q.delete();
    send_byte(8'h08);
    checks++;
    if (cursor_col !== 8'd2 || cursor_row !== 6'd2) begin
      failures++;
      $display("FAIL bs1_cursor: cur=(%0d,%0d) required (2,2)", cursor_col, cursor_row);
    end
    send_byte(8'h08);
    send_byte(8'h0D);
    checks++;
    if (cursor_col !== 8'd0 || cursor_row !== 6'd2) begin
      failures++;
      $display("FAIL cr_cursor: cur=(%0d,%0d) required (0,2)", cursor_col, cursor_row);
    end
    send_byte(8'h08);
    settle();
    checks++;
    if (cursor_col !== 8'd0 || cursor_row !== 6'd2 || act_q.size() != 2) begin
      failures++;
      $display("FAIL bs_col0: cur=(%0d,%0d) writes=%0d required (0,2) 2", cursor_col, cursor_row, act_q.size());
    end else begin
      checks++;
      if (act_q[0] !== w0 || act_q[1] !== w1) begin
        failures++;
        $display("FAIL bs_writes: got %h %h required %h %h", act_q[0], act_q[1], w0, w1);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_ff();
    int run = 0;
    int d;
    logic last_ready = 1'b0;
    send_byte(8'h0C);
    checks++;
    if (cursor_col !== 8'd0 || cursor_row !== 6'd0 || tw_if.wr_en_o !== 1'b0) begin
      failures++;
      $display("FAIL ff_cursor: cur=(%0d,%0d) wr_en=%b required (0,0) 0", cursor_col, cursor_row, tw_if.wr_en_o);
    end
    @(negedge clk);
    while (tw_if.wr_en_o === 1'b1 && run < 20000) begin
      last_ready = tw_if.ready_o;
      run++;
      @(negedge clk);
    end
    checks++;
    if (run != 10240 || last_ready !== 1'b1) begin
      failures++;
      $display("FAIL ff_sweep: consecutive writes=%0d ready_at_end=%b required 10240 1", run, last_ready);
    end
    settle();
    d = stream_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL ff_stream: first diff at %0d, writes=%0d required %0d", d, act_q.size(), exp_q.size());
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_sweep();
    int bad = 0;
    send_byte(8'h0C);
    repeat (500) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (tw_if.wr_en_o !== 1'b0 || busy !== 1'b0 || tw_if.ready_o !== 1'b1 ||
        cursor_col !== 8'd0 || cursor_row !== 6'd0) begin
      failures++;
      $display("FAIL abort_outputs: wr_en=%b busy=%b ready=%b cur=(%0d,%0d) required 0 0 1 (0,0)",
               tw_if.wr_en_o, busy, tw_if.ready_o, cursor_col, cursor_row);
    end
    foreach (act_q[i]) if (i < exp_q.size() && act_q[i] !== exp_q[i]) bad++;
    checks++;
    if (act_q.size() != 500 || bad != 0) begin
      failures++;
      $display("FAIL abort_prefix: writes=%0d wrong=%0d required 500 0", act_q.size(), bad);
    end
    @(negedge clk);
    rstn = 1'b1;
    act_q.delete(); exp_q.delete();
    m_col = 0; m_row = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (tw_if.wr_en_o !== 1'b0 || busy !== 1'b0 || act_q.size() != 0) begin
      failures++;
      $display("FAIL abort_idle: wr_en=%b busy=%b writes=%0d required 0 0 0", tw_if.wr_en_o, busy, act_q.size());
    end
  endtask

  task automatic test_tab();
    int d;
    for (int i = 0; i < 3; i++) send_byte(8'h61);
    send_byte(8'h09);
    checks++;
`ifdef TEXT_WRITER_TAB_EN
    if (cursor_col !== 8'd8 || cursor_row !== 6'd0) begin
      failures++;
      $display("FAIL tab_col3: cur=(%0d,%0d) required (8,0)", cursor_col, cursor_row);
    end
    send_byte(8'h0D);
    for (int i = 0; i < 157; i++) send_byte(8'h61);
    send_byte(8'h09);
    checks++;
    if (cursor_col !== 8'd0 || cursor_row !== 6'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL tab_col157: cur=(%0d,%0d) busy=%b required (0,1) 1", cursor_col, cursor_row, busy);
    end
`else
    if (cursor_col !== 8'd3 || cursor_row !== 6'd0) begin
      failures++;
      $display("FAIL tab_ignored: cur=(%0d,%0d) required (3,0)", cursor_col, cursor_row);
    end
`endif
    settle();
    d = stream_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL tab_stream: first diff at %0d", d);
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int d;
    for (int n = 0; n < 400; n++) begin
      int k = $urandom_range(0, 99);
      logic [7:0] b;
      if (k < 60) b = 8'($urandom_range(32, 126));
      else if (k < 66) b = 8'h0A;
      else if (k < 72) b = 8'h0D;
      else if (k < 84) b = 8'h08;
      else if (k < 90) b = 8'h09;
      else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0C) b = 8'h7F;
      end
      send_byte(b);
      checks++;
      if (cursor_col !== 8'(m_col) || cursor_row !== 6'(m_row)) begin
        failures++;
        $display("FAIL rand_cursor: byte %h cur=(%0d,%0d) required (%0d,%0d)", b, cursor_col, cursor_row, m_col, m_row);
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    settle();
    d = stream_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL rand_stream: first diff at %0d, writes=%0d required %0d", d, act_q.size(), exp_q.size());
    end
  endtask

  initial begin
    rstn          = 1'b0;
    tw_if.valid_i = 1'b0;
    tw_if.char_i  = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_char();
    test_back_to_back();
    test_lf();
    test_bs_cr();
    test_ff();
    test_reset_mid_sweep();
    test_tab();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
